// File: rtl/coin_pkg.sv
// Shared definitions for the coin dispense sequencer: FSM state encoding,
// datapath widths and a saturating decrement for the coin counter.
package coin_pkg;

    localparam int ANGLE_W = 9;
    localparam int COUNT_W = 4;
    localparam int DWELL_W = 26;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH    = 2'd1,
        RETRACT = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Decrement that sticks at zero so the coin counter can never underflow.
    function automatic logic [COUNT_W-1:0] dec_sat(input logic [COUNT_W-1:0] value);
        return (value == '0) ? '0 : value - 1'b1;
    endfunction

endpackage

// File: rtl/coin_dispense_seq_dwell_timer.sv
// Dwell timer for one servo phase. The count restarts from zero on every
// start pulse and advances only while enabled. expired is high during the
// last cycle of a DWELL_CYCLES-long phase. The counter holds at that value
// rather than wrapping.
module dwell_timer
    import coin_pkg::*;
#(
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic start,
    input  logic en,
    output logic expired
);

    localparam logic [DWELL_W-1:0] LAST_COUNT = DWELL_W'(DWELL_CYCLES - 1);

    logic [DWELL_W-1:0] count_reg;

    // Count cycles spent in the current phase; restart on every state entry.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST_COUNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST_COUNT);

endmodule

// File: rtl/coin_dispense_seq.sv
// Coin dispense sequencer: for a request of k coins the servo is swung to
// PUSH_ANGLE and back to REST_ANGLE k times, each phase lasting DWELL_CYCLES,
// followed by a one-cycle done pulse. All outputs are registered and change
// together with the state.
// Optional feature: define COIN_SEQ_ABORT_EN to add the abort input, which
// sends the servo home and ends the request after one retract phase.
module coin_dispense_seq
    import coin_pkg::*;
#(
    parameter int DWELL_CYCLES = 25_000_000,
    parameter int PUSH_ANGLE   = 90,
    parameter int REST_ANGLE   = 0
) (
    input  logic               clk,
    input  logic               clr_n,
`ifdef COIN_SEQ_ABORT_EN
    input  logic               abort,
`endif
    input  logic               req_valid,
    input  logic [COUNT_W-1:0] req_count,
    output logic               req_ready,
    output logic [ANGLE_W-1:0] angle,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] coins_left
);

    localparam logic [ANGLE_W-1:0] PUSH_A = ANGLE_W'(PUSH_ANGLE);
    localparam logic [ANGLE_W-1:0] REST_A = ANGLE_W'(REST_ANGLE);

    state_t             state_reg;
    logic [ANGLE_W-1:0] angle_reg;
    logic               ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [COUNT_W-1:0] coins_reg;

    logic               timer_start;
    logic               timer_en;
    logic               timer_expired;
    logic [COUNT_W-1:0] retract_coins;
    logic [COUNT_W-1:0] retract_coins_dec;
    logic               push_abort;

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (timer_start),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // Abort effects: in PUSH it cuts the stroke short; in RETRACT it shrinks
    // the remaining work to the coin currently being retracted.
    always_comb begin
        push_abort    = 1'b0;
        retract_coins = coins_reg;
`ifdef COIN_SEQ_ABORT_EN
        push_abort = abort;
        if (abort) begin
            retract_coins = COUNT_W'(1);
        end
`endif
        retract_coins_dec = dec_sat(retract_coins);
    end

    // Timer restart strobe: asserted on every edge that changes the state,
    // so each phase starts counting from zero.
    always_comb begin
        timer_start = 1'b0;
        timer_en    = (state_reg == PUSH) || (state_reg == RETRACT);
        case (state_reg)
            IDLE:    timer_start = req_valid;
            PUSH:    timer_start = timer_expired || push_abort;
            RETRACT: timer_start = timer_expired;
            DONE:    timer_start = 1'b1;
            default: timer_start = 1'b1;
        endcase
    end

    // Sequencer FSM; outputs are updated on the same edge as the state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
            angle_reg <= REST_A;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            coins_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                        if (req_count == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            coins_reg <= '0;
                        end else begin
                            state_reg <= PUSH;
                            angle_reg <= PUSH_A;
                            coins_reg <= req_count;
                        end
                    end
                end
                PUSH: begin
                    if (push_abort) begin
                        state_reg <= RETRACT;
                        angle_reg <= REST_A;
                        coins_reg <= COUNT_W'(1);
                    end else if (timer_expired) begin
                        state_reg <= RETRACT;
                        angle_reg <= REST_A;
                    end
                end
                RETRACT: begin
                    if (timer_expired) begin
                        coins_reg <= retract_coins_dec;
                        if (retract_coins_dec == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= PUSH;
                            angle_reg <= PUSH_A;
                        end
                    end else begin
                        coins_reg <= retract_coins;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    angle_reg <= REST_A;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    coins_reg <= '0;
                end
            endcase
        end
    end

    assign angle      = angle_reg;
    assign req_ready  = ready_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign coins_left = coins_reg;

endmodule

// File: tb/tb_coin_dispense_seq.sv
// Self-checking bench for coin_dispense_seq with DWELL_CYCLES=4, PUSH_ANGLE=90,
// REST_ANGLE=0. A per-cycle vector table covers single coin, zero coins,
// back-to-back and busy-ignore; hand-written sequences cover multi-coin,
// asynchronous reset mid-sequence and (with COIN_SEQ_ABORT_EN) abort.
module tb_coin_dispense_seq;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       clr_n;
`ifdef COIN_SEQ_ABORT_EN
    logic       abort;
`endif
    logic       req_valid;
    logic [3:0] req_count;
    logic       req_ready;
    logic [8:0] angle;
    logic       busy;
    logic       done;
    logic [3:0] coins_left;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       v;
        logic [3:0] c;
        logic [8:0] a;
        logic       rdy;
        logic       bsy;
        logic       dn;
        logic [3:0] cl;
    } vec_t;

    vec_t vecs[$];

    coin_dispense_seq #(
        .DWELL_CYCLES (DW),
        .PUSH_ANGLE   (90),
        .REST_ANGLE   (0)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
`ifdef COIN_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .req_valid  (req_valid),
        .req_count  (req_count),
        .req_ready  (req_ready),
        .angle      (angle),
        .busy       (busy),
        .done       (done),
        .coins_left (coins_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int a, input int rdy,
                           input int bsy, input int dn, input int cl);
        checks++;
        if (angle != 9'(a) || req_ready != 1'(rdy) || busy != 1'(bsy) ||
            done != 1'(dn) || coins_left != 4'(cl)) begin
            errors++;
            $display("FAIL %s: got angle=%0d ready=%0d busy=%0d done=%0d coins=%0d expected angle=%0d ready=%0d busy=%0d done=%0d coins=%0d",
                     name, angle, req_ready, busy, done, coins_left, a, rdy, bsy, dn, cl);
        end
    endtask

    task automatic add_n(input int n, input int v, input int c, input int a,
                         input int rdy, input int bsy, input int dn, input int cl);
        vec_t t;
        t.v   = 1'(v);
        t.c   = 4'(c);
        t.a   = 9'(a);
        t.rdy = 1'(rdy);
        t.bsy = 1'(bsy);
        t.dn  = 1'(dn);
        t.cl  = 4'(cl);
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    // Issue a request on the next edge; returns #1 after that edge (cycle 1).
    task automatic handshake(input int k);
        @(negedge clk);
        req_valid = 1'b1;
        req_count = 4'(k);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_count = 4'd0;
        $display("txn: request of %0d coins issued", k);
    endtask

    // From cycle 1, step until done is seen; cyc is the cycle number or -1.
    task automatic wait_done(input int bound, output int cyc);
        cyc = -1;
        for (int c = 1; c <= bound; c++) begin
            if (done) begin
                cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cyc;
        int pushes;
        int prev_a;
        int exp_a;
        int done_seen;
        int coin_trace[$];

        clr_n     = 1'b0;
        req_valid = 1'b0;
        req_count = 4'd0;
`ifdef COIN_SEQ_ABORT_EN
        abort     = 1'b0;
`endif

        // Per-cycle table: inputs applied before an edge, outputs expected after it.
        // Single coin k=1: push cycles 1-4, retract 5-8, done at cycle 9.
        add_n(1, 1, 1, 90, 0, 1, 0, 1);
        add_n(3, 0, 0, 90, 0, 1, 0, 1);
        add_n(4, 0, 0,  0, 0, 1, 0, 1);
        add_n(1, 0, 0,  0, 0, 1, 1, 0);
        add_n(2, 0, 0,  0, 1, 0, 0, 0);
        // Zero coins: straight to done, angle stays at rest.
        add_n(1, 1, 0,  0, 0, 1, 1, 0);
        // Valid held with k=2 through DONE: accepted on the first IDLE cycle.
        add_n(1, 1, 2,  0, 1, 0, 0, 0);
        add_n(1, 1, 2, 90, 0, 1, 0, 2);
        // Requests while busy are ignored.
        add_n(1, 1, 9, 90, 0, 1, 0, 2);
        add_n(2, 0, 0, 90, 0, 1, 0, 2);
        add_n(2, 0, 0,  0, 0, 1, 0, 2);
        add_n(1, 1, 7,  0, 0, 1, 0, 2);
        add_n(1, 0, 0,  0, 0, 1, 0, 2);
        add_n(4, 0, 0, 90, 0, 1, 0, 1);
        add_n(4, 0, 0,  0, 0, 1, 0, 1);
        add_n(1, 0, 0,  0, 0, 1, 1, 0);
        add_n(1, 0, 0,  0, 1, 0, 0, 0);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset_state", 0, 1, 0, 0, 0);
        @(negedge clk);
        clr_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req_valid = vecs[i].v;
            req_count = vecs[i].c;
            @(posedge clk);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].a, vecs[i].rdy, vecs[i].bsy,
                    vecs[i].dn, vecs[i].cl);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_count = 4'd0;

        // Multi coin k=3: three strokes, coins 3->2->1->0, done at cycle 25.
        handshake(3);
        done_cyc = -1;
        pushes   = 0;
        prev_a   = 0;
        coin_trace.delete();
        coin_trace.push_back(int'(coins_left));
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            exp_a = (((c - 1) % (2 * DW)) < DW) ? 90 : 0;
            chk($sformatf("multi_angle_c%0d", c), int'(angle), exp_a);
            if (int'(angle) == 90 && prev_a == 0) pushes++;
            prev_a = int'(angle);
            if (int'(coins_left) != coin_trace[coin_trace.size() - 1])
                coin_trace.push_back(int'(coins_left));
            @(posedge clk);
            #1;
        end
        if (done_cyc > 0 && int'(coins_left) != coin_trace[coin_trace.size() - 1])
            coin_trace.push_back(int'(coins_left));
        chk("multi_done_cycle", done_cyc, 2 * 3 * DW + 1);
        chk("multi_push_count", pushes, 3);
        chk("multi_trace_len", coin_trace.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < coin_trace.size())
                chk($sformatf("multi_trace%0d", j), coin_trace[j], 3 - j);
        end
        @(posedge clk);
        #1;
        chk_out("multi_back_idle", 0, 1, 0, 0, 0);

        // Reset mid-PUSH with k=3: immediate IDLE outputs, no done pulse.
        handshake(3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("pre_reset_push", 90, 0, 1, 0, 3);
        #2;
        clr_n = 1'b0;
        #1;
        chk_out("async_reset_outputs", 0, 1, 0, 0, 0);
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1;
        end
        chk("reset_no_done", done_seen, 0);
        // Release and request on the very first edge after deassertion.
        @(negedge clk);
        clr_n     = 1'b1;
        req_valid = 1'b1;
        req_count = 4'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_count = 4'd0;
        $display("txn: request of 1 coin issued right after reset release");
        chk_out("post_reset_push", 90, 0, 1, 0, 1);
        wait_done(40, done_cyc);
        chk("post_reset_done_cycle", done_cyc, 2 * DW + 1);
        @(posedge clk);
        #1;

`ifdef COIN_SEQ_ABORT_EN
        // Abort during the 2nd PUSH of k=5: retract 4 cycles, then done.
        handshake(5);
        repeat (9) @(posedge clk);
        #1;
        chk_out("abort_second_push", 90, 0, 1, 0, 4);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk_out("abort_retract", 0, 0, 1, 0, 1);
        wait_done(40, done_cyc);
        chk("abort_done_delay", done_cyc, DW + 1);
        chk_out("abort_done_outputs", 0, 0, 1, 1, 0);
        @(posedge clk);
        #1;
        chk_out("abort_back_idle", 0, 1, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_dispense_seq.md
COIN_DISPENSE_SEQ -- requirements
Module: coin_dispense_seq

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 25_000_000, clock cycles per servo phase (250 ms at 100 MHz), legal range 1..2^26-1.
REQ-002 SHALL have parameter PUSH_ANGLE, default 90, servo angle in degrees for the eject stroke, legal range 0..180.
REQ-003 SHALL have parameter REST_ANGLE, default 0, servo angle in degrees for the home position, legal range 0..180.
REQ-004 clk  in  1  system clock, rising-edge active.
REQ-005 clr_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 req_valid  in  1  dispense request present.
REQ-007 req_count  in  4  number of coins to eject, 0..15.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 angle  out  9  commanded servo angle in degrees, feeds the servo PWM angle decoder.
REQ-010 busy  out  1  sequence in progress (any state except IDLE).
REQ-011 done  out  1  one-cycle pulse at end of a request.
REQ-012 coins_left  out  4  coins not yet fully ejected in the current request.
REQ-013 abort  in  1  cancel the current request; port exists only when COIN_SEQ_ABORT_EN is defined.

Function
REQ-014 SHALL implement the FSM states IDLE, PUSH, RETRACT and DONE.
REQ-015 req_ready SHALL equal 1 only in IDLE.
REQ-016 A handshake SHALL occur on a rising edge where req_valid=1 and req_ready=1; req_count SHALL be sampled on that edge only.
REQ-017 On a handshake with req_count=0, the FSM SHALL go IDLE->DONE with no motion, and coins_left SHALL remain 0.
REQ-018 On a handshake with req_count=k>0, the FSM SHALL go IDLE->PUSH, load coins_left=k, and drive angle=PUSH_ANGLE from the next cycle.
REQ-019 PUSH and RETRACT SHALL each last exactly DWELL_CYCLES cycles, then transition: PUSH->RETRACT, with angle=REST_ANGLE.
REQ-020 At the end of RETRACT, coins_left SHALL decrement; if the result is nonzero the FSM SHALL go to PUSH, else to DONE.
REQ-021 DONE SHALL last one cycle with done=1, then go to IDLE; done SHALL be 0 in all other states.
REQ-022 For k coins, the handshake-to-done latency SHALL be 2*k*DWELL_CYCLES+1 cycles.
REQ-023 angle SHALL equal REST_ANGLE in IDLE, RETRACT and DONE, and PUSH_ANGLE in PUSH.
REQ-024 The dwell counter SHALL be 26 bits, SHALL clear on every state entry, and SHALL not wrap.
REQ-025 A req_valid held high through DONE SHALL be accepted in the first IDLE cycle; requests while busy SHALL be ignored, not queued.
REQ-026 coins_left SHALL never underflow.

Reset
REQ-027 On clr_n=0, state SHALL become IDLE immediately, asynchronously.
REQ-028 On clr_n=0, the outputs SHALL be angle=REST_ANGLE, req_ready=1, busy=0, done=0, coins_left=0, and the dwell counter SHALL be 0.
REQ-029 Reset mid-sequence SHALL abandon the request with no done pulse.
REQ-030 Release SHALL be synchronised by the caller; the block SHALL operate normally from the first edge after deassertion.

Configuration
REQ-031 Macro COIN_SEQ_ABORT_EN defined: abort=1 sampled in PUSH SHALL force RETRACT with a fresh dwell and coins_left=1, giving a safe home.
REQ-032 Macro COIN_SEQ_ABORT_EN defined: abort=1 sampled in RETRACT SHALL set coins_left=1 so DONE follows the dwell.
REQ-033 Macro COIN_SEQ_ABORT_EN defined: abort SHALL be ignored in IDLE and DONE, and done SHALL still pulse.
REQ-034 Macro COIN_SEQ_ABORT_EN undefined: the abort port and its logic SHALL be absent and behaviour SHALL be as in REQ-014..026.

Structure
REQ-035 Shared package coin_pkg SHALL hold the state enum, ANGLE_W=9, COUNT_W=4 and DWELL_W=26.
REQ-036 Sub-module dwell_timer (inputs start and en, output expired at DWELL_CYCLES) SHALL be instantiated once.

Verification (DWELL_CYCLES=4)
REQ-037 Reset: clr_n low mid-PUSH with k=3 -> outputs immediately IDLE values, and no done pulse.
REQ-038 Single coin: k=1 -> angle 90 for 4 cycles, then 0 for 4 cycles, done at cycle 9 after the handshake.
REQ-039 Multi coin: k=3 -> three 90/0 pulses, coins_left 3->2->1->0, done at cycle 25.
REQ-040 Zero and back-to-back: k=0 -> done on cycle 1 with angle constant 0; valid held with k=2 -> second handshake on the first IDLE cycle after done.
REQ-041 Busy ignore: req_valid pulsed during PUSH -> no handshake, and coins_left unchanged.
REQ-042 Abort (COIN_SEQ_ABORT_EN): k=5, abort in 2nd PUSH -> RETRACT 4 cycles, then done, and coins_left=0.
